// File: rtl/ppu_vram_resp.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_resp
// Brief    : PPU-side VRAM responder. Decodes the 14-bit PPU space into
//            external CHR, 2 KiB mirrored nametable RAM and 32-entry palette
//            RAM, answers renderer fetches with one cycle of latency and
//            slots CPU reads/writes (via a one-entry posted write buffer)
//            into cycles the renderer leaves free.
// Options  : PPU_VRAM_CHR_RAM_EN - when defined, CPU writes to 0000-1FFF are
//            driven onto chr_we/chr_addr/chr_wdata; otherwise discarded.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] VRAM_addr,
  output logic [7:0]  VRAM_data,
  input  logic        rendering,
  input  logic        mirror_vertical,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] chr_addr,
  input  logic [7:0]  chr_rdata,
  output logic        chr_we,
  output logic [7:0]  chr_wdata
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_WAIT  = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [13:0] r_buf_addr;
  logic [7:0]  r_buf_data;
  logic        r_buf_full;
  logic        r_ack;

  logic        w_drain;
  logic        w_wr_capture;
  logic [13:0] w_port_addr;
  logic        w_port_is_chr;
  logic        w_port_is_pal;
  logic [10:0] w_nt_idx;
  logic [4:0]  w_pal_idx;

  logic [7:0]  r_nt_ram  [0:2047];
  logic [5:0]  r_pal_ram [0:31];

  logic        r_rd_is_chr;
  logic [7:0]  r_ram_rdata;
  logic [7:0]  w_rd_data;

  // Address bits 15:14 of the renderer bus do not exist in PPU space.
  logic        w_unused;
  assign w_unused = ^VRAM_addr[15:14];

  // The buffered write retires in any cycle the renderer and a CPU read
  // issue both leave the memory port alone.
  assign w_drain      = r_buf_full && !rendering && (r_state != S_RD_ISSUE);
  assign w_wr_capture = (r_state == S_IDLE) && cpu_req && cpu_we && !r_buf_full;

  // Shared memory port address: CPU read issue, else write drain, else renderer.
  always_comb begin
    w_port_addr = VRAM_addr[13:0];
    if (r_state == S_RD_ISSUE) begin
      w_port_addr = cpu_addr;
    end else if (w_drain) begin
      w_port_addr = r_buf_addr;
    end
  end

  // Region decode; palette entries 10/14/18/1C fold onto 00/04/08/0C.
  assign w_port_is_chr = ~w_port_addr[13];
  assign w_port_is_pal = (w_port_addr[13:8] == 6'h3F);
  assign w_nt_idx      = {(mirror_vertical ? w_port_addr[10] : w_port_addr[11]),
                          w_port_addr[9:0]};
  assign w_pal_idx     = {(w_port_addr[4] && (w_port_addr[1:0] != 2'b00)),
                          w_port_addr[3:0]};

  // Internal RAM write port, used only by the buffer drain (contents not reset).
  always_ff @(posedge clk) begin
    if (w_drain && !w_port_is_chr) begin
      if (w_port_is_pal) begin
        r_pal_ram[w_pal_idx] <= r_buf_data[5:0];
      end else begin
        r_nt_ram[w_nt_idx] <= r_buf_data;
      end
    end
  end

  // Synchronous internal read, aligned with the external CHR read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_is_chr <= 1'b0;
      r_ram_rdata <= 8'h00;
    end else begin
      r_rd_is_chr <= w_port_is_chr;
      r_ram_rdata <= w_port_is_pal ? {2'b00, r_pal_ram[w_pal_idx]}
                                   : r_nt_ram[w_nt_idx];
    end
  end

  assign w_rd_data = r_rd_is_chr ? chr_rdata : r_ram_rdata;

  // Renderer response register; carries CPU read data in the RD_DONE cycle too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      VRAM_data <= 8'h00;
    end else begin
      VRAM_data <= w_rd_data;
    end
  end

  // Read FSM next-state; reads wait for an empty buffer so they never bypass it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (cpu_req && !cpu_we)        w_state_next = S_RD_WAIT;
      S_RD_WAIT:  if (!r_buf_full && !rendering) w_state_next = S_RD_ISSUE;
      S_RD_ISSUE: w_state_next = S_RD_DONE;
      S_RD_DONE:  w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // FSM state, write buffer, ack pulse and CPU read data holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_buf_full <= 1'b0;
      r_buf_addr <= 14'h0000;
      r_buf_data <= 8'h00;
      r_ack      <= 1'b0;
      cpu_rdata  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_wr_capture || (r_state == S_RD_DONE);
      if (w_wr_capture) begin
        r_buf_full <= 1'b1;
        r_buf_addr <= cpu_addr;
        r_buf_data <= cpu_wdata;
      end else if (w_drain) begin
        r_buf_full <= 1'b0;
      end
      if (r_state == S_RD_DONE) begin
        cpu_rdata <= w_rd_data;
      end
    end
  end

  assign cpu_ack  = r_ack;
  // External CHR memory samples this address itself; hold it at 0 in reset.
  assign chr_addr = reset ? w_port_addr[12:0] : 13'h0000;

`ifdef PPU_VRAM_CHR_RAM_EN
  assign chr_we    = w_drain && w_port_is_chr;
  assign chr_wdata = chr_we ? r_buf_data : 8'h00;
`else
  assign chr_we    = 1'b0;
  assign chr_wdata = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_vram_resp
// Brief    : Self-checking bench for ppu_vram_resp: reset state, CPU write /
//            read latency, mirroring, palette aliasing, table-driven renderer
//            sweep, arbitration against rendering, reset mid-read and CHR
//            write behaviour (with or without PPU_VRAM_CHR_RAM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] VRAM_addr;
  logic [7:0]  VRAM_data;
  logic        rendering;
  logic        mirror_vertical;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [12:0] chr_addr;
  logic [7:0]  chr_rdata;
  logic        chr_we;
  logic [7:0]  chr_wdata;

  ppu_vram_resp dut (
    .clk             (clk),
    .reset           (reset),
    .VRAM_addr       (VRAM_addr),
    .VRAM_data       (VRAM_data),
    .rendering       (rendering),
    .mirror_vertical (mirror_vertical),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_ack         (cpu_ack),
    .cpu_rdata       (cpu_rdata),
    .chr_addr        (chr_addr),
    .chr_rdata       (chr_rdata),
    .chr_we          (chr_we),
    .chr_wdata       (chr_wdata)
  );

  always #5 clk = ~clk;

  // External CHR ROM/RAM model: synchronous read, preset contents.
  logic [7:0] chr_mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
    chr_mem[13'h1234] = 8'hA5;
  end
  always @(posedge clk) chr_rdata <= chr_mem[chr_addr];

  // CHR write strobe monitor.
  int we_cnt = 0;
`ifdef PPU_VRAM_CHR_RAM_EN
  logic [7:0]  last_wdata = 8'h00;
  logic [12:0] last_waddr = 13'h0000;
`endif
  always @(posedge clk) begin
    if (chr_we) begin
      we_cnt <= we_cnt + 1;
`ifdef PPU_VRAM_CHR_RAM_EN
      last_wdata <= chr_wdata;
      last_waddr <= chr_addr;
`endif
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp;
    string       name;
  } rvec_t;
  rvec_t vecs [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic render_read(input logic [15:0] a, input logic [7:0] e, input string nm);
    VRAM_addr = a;
    sb_q.push_back(e);
    tick();
    tick();
    check(nm, {24'h0, VRAM_data}, {24'h0, sb_q.pop_front()});
  endtask

  task automatic cpu_write(input logic [13:0] a, input logic [7:0] d, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      lat++;
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    check("wr_ack", {31'h0, got}, 32'h1);
    tick();
  endtask

  task automatic cpu_read(input logic [13:0] a, input logic [7:0] e, input string nm,
                          output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    sb_q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      lat++;
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    check({nm, "_ack"}, {31'h0, got}, 32'h1);
    check(nm, {24'h0, cpu_rdata}, {24'h0, sb_q.pop_front()});
    tick();
  endtask

  int lat;
  int we_before;
  logic seen;

  initial begin
    vecs[0] = '{16'h3F05, 8'h2A, "rd_pal05"};
    vecs[1] = '{16'h7F05, 8'h2A, "rd_pal05_hibits"};
    vecs[2] = '{16'h1234, 8'hA5, "rd_chr1234"};
    vecs[3] = '{16'hD234, 8'hA5, "rd_chr_hibits"};
    vecs[4] = '{16'h2C00, 8'h66, "rd_nt2C00"};
    vecs[5] = '{16'h2000, 8'hAA, "rd_nt2000"};
    vecs[6] = '{16'h3F00, 8'h3F, "rd_pal00"};
    vecs[7] = '{16'h3F10, 8'h3F, "rd_pal10_alias"};

    reset = 1'b0; VRAM_addr = 16'h1234; rendering = 1'b0; mirror_vertical = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0; cpu_wdata = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_VRAM_data", {24'h0, VRAM_data}, 32'h0);
    check("rst_cpu_ack",   {31'h0, cpu_ack},   32'h0);
    check("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);
    check("rst_chr_addr",  {19'h0, chr_addr},  32'h0);
    check("rst_chr_we",    {31'h0, chr_we},    32'h0);
    check("rst_chr_wdata", {24'h0, chr_wdata}, 32'h0);
    reset = 1'b1;
    tick();

    // Preload and mirroring, vertical: A10 picks the page.
    cpu_write(14'h3F05, 8'h2A, lat);
    check("wr_latency", lat, 1);
    cpu_write(14'h2000, 8'hAA, lat);
    cpu_write(14'h2400, 8'h55, lat);
    cpu_read(14'h2C00, 8'h55, "rdv_2C00", lat);
    check("rd_latency", lat, 4);
    cpu_read(14'h2000, 8'hAA, "rdv_2000", lat);
    // Horizontal: A11 picks the page, so 2800 and 2C00 alias.
    mirror_vertical = 1'b0;
    cpu_write(14'h2800, 8'h66, lat);
    cpu_read(14'h2C00, 8'h66, "rdh_2C00", lat);
    cpu_read(14'h2400, 8'hAA, "rdh_2400", lat);
    // Palette alias and 6-bit storage.
    cpu_write(14'h3F10, 8'hFF, lat);
    cpu_read(14'h3F00, 8'h3F, "rd_pal_alias", lat);

    // Renderer sweep.
    rendering = 1'b1;
    VRAM_addr = 16'h1234;
    #1;
    check("chr_addr_render", {19'h0, chr_addr}, 32'h1234);
    for (int i = 0; i < 8; i++) render_read(vecs[i].addr, vecs[i].exp, vecs[i].name);

    // Arbitration: write posts while rendering, read waits for rendering to drop.
    cpu_write(14'h2005, 8'h12, lat);
    check("arb_wr_latency", lat, 1);
    sb_q.push_back(8'h12);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | cpu_ack;
    end
    check("arb_ack_held", {31'h0, seen}, 32'h0);
    // Drop rendering: drain, then WAIT->ISSUE->DONE->ack = 4 edges.
    rendering = 1'b0;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      seen = cpu_ack;
    end
    cpu_req = 1'b0;
    check("arb_rd_ack", {31'h0, seen}, 32'h1);
    check("arb_rd_latency", lat, 4);
    check("arb_rd_data", {24'h0, cpu_rdata}, {24'h0, sb_q.pop_front()});
    tick();

    // CHR write.
    we_before = we_cnt;
    cpu_write(14'h0010, 8'h77, lat);
    check("chr_wr_latency", lat, 1);
    tick();
`ifdef PPU_VRAM_CHR_RAM_EN
    check("chr_we_pulses", we_cnt - we_before, 1);
    check("chr_wdata",     {24'h0, last_wdata}, 32'h77);
    check("chr_waddr",     {19'h0, last_waddr}, 32'h0010);
`else
    check("chr_we_pulses", we_cnt - we_before, 0);
`endif

    // Reset while a read sits in RD_WAIT.
    rendering = 1'b1;
    VRAM_addr = 16'h3F10;
    tick();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst2_VRAM_data", {24'h0, VRAM_data}, 32'h0);
    check("rst2_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);
    check("rst2_chr_addr",  {19'h0, chr_addr},  32'h0);
    check("rst2_cpu_ack",   {31'h0, cpu_ack},   32'h0);
    cpu_req = 1'b0;
    rendering = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | cpu_ack;
    end
    check("rst2_no_ack", {31'h0, seen}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ppu_vram_resp.md
# ppu_vram_resp

PPU-side VRAM responder: the memory end of the renderer's VRAM read interface. Decodes the 14-bit PPU address space into CHR (external pattern memory), 2 KiB internal nametable RAM with selectable mirroring, and 32-entry palette RAM. Returns renderer read data with fixed one-cycle latency. Arbitrates CPU (PPUDATA-path) reads and writes into the same memories whenever the renderer is not fetching, using a one-entry posted write buffer.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- VRAM_addr  in  16  renderer fetch address; bits 15:14 ignored
- VRAM_data  out  8  renderer read data, registered
- rendering  in  1  1 = renderer owns the memories this cycle
- mirror_vertical  in  1  1 = vertical mirroring (A10 selects page), 0 = horizontal (A11)
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  14  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data, valid with cpu_ack, held until next read completes
- chr_addr  out  13  external CHR address (synchronous, 1-cycle read latency)
- chr_rdata  in  8  external CHR read data
- chr_we  out  1  CHR write strobe
- chr_wdata  out  8  CHR write data

## Operation
- Decode of a 14-bit address A: 0000-1FFF CHR (chr_addr = A[12:0]); 2000-3EFF nametable, index = {mirror_vertical ? A[10] : A[11], A[9:0]}; 3F00-3FFF palette, index = A[4:0] with 10/14/18/1C aliased to 00/04/08/0C.
- Palette stores 6 bits; reads return {2'b00, data[5:0]}.
- Memory port source: renderer address when no CPU access is issuing; CPU address in RD_ISSUE or write-drain cycles.
- Write buffer (1 entry: addr, data, full flag). An idle write request with buffer empty is captured; cpu_ack pulses the next cycle. If the buffer is full, the request waits.
- Drain: buffer full, rendering = 0, state not RD_ISSUE -> write performed that cycle, full cleared.
- Read FSM: IDLE -> RD_WAIT on cpu_req & !cpu_we. RD_WAIT -> RD_ISSUE when buffer empty and rendering = 0. RD_ISSUE -> RD_DONE unconditionally. RD_DONE latches the decoded data into cpu_rdata, pulses cpu_ack, and returns to IDLE.
- Once in RD_ISSUE, the access commits even if rendering rises. The renderer response for that cycle carries the CPU read data.
- Reads never bypass the write buffer; a read after a write to the same address returns the new value.

## Timing
- Renderer: VRAM_addr sampled at edge N; VRAM_data valid after edge N+1, every cycle, all three regions.
- CPU write, buffer empty: cpu_ack high in the cycle after the request is first sampled.
- CPU read, idle, rendering = 0, buffer empty: request sampled at E0; cpu_ack/cpu_rdata asserted after E3.
- cpu_ack is never high for two consecutive cycles. The requester must drop cpu_req in the ack cycle, or it is re-sampled as a new request.
- Reset values: VRAM_data = 0, cpu_ack = 0, cpu_rdata = 0, chr_addr = 0, chr_we = 0, chr_wdata = 0, FSM = IDLE, buffer empty. RAM contents are not reset.
- Reset mid-read or with the buffer full: the operation is dropped and no ack is issued.

## Configuration
- PPU_VRAM_CHR_RAM_EN defined: CPU writes to 0000-1FFF drive chr_we (one cycle), chr_addr, and chr_wdata during the drain cycle.
- Not defined: chr_we is tied 0 and chr_wdata to 0. CHR writes are still acked and buffered, but discarded at drain.

## Test plan
- Renderer sweep, rendering = 1: palette[0x05] = 0x2A preloaded, VRAM_addr = 0x3F05 -> VRAM_data = 0x2A one cycle later; CHR addr 0x1234 -> chr_addr = 0x1234, returns chr_rdata.
- Mirroring: CPU write 0x55 to 0x2400 with mirror_vertical = 1 -> read of 0x2C00 returns 0x55 and 0x2000 does not. With mirror_vertical = 0, 0x2800 aliases 0x2C00.
- Palette alias: write 0xFF to 0x3F10 -> read 0x3F00 returns 0x3F.
- Arbitration: rendering = 1, CPU write 0x12 to 0x2005 then read 0x2005 -> write acked next cycle; read ack withheld until rendering drops; after that, ack arrives 3 cycles later with 0x12.
- Reset asserted in RD_WAIT -> no cpu_ack; all outputs 0 while reset is low.
- CHR write 0x77 to 0x0010: with PPU_VRAM_CHR_RAM_EN -> chr_we pulses with chr_wdata = 0x77. Without it -> cpu_ack pulses, chr_we stays 0.
